// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per clock
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              annul,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d, dbz_q, dbz_d;
  logic [DATA_W:0] sh, diff;
  logic ge, opb_zero;
  assign opb_zero = opb == '0;
  assign sh = {rem_q, dvd_q[DATA_W-1]};
  assign diff = sh - {1'b0, dvs_q};
  assign ge = ~diff[DATA_W];
  assign busy = state_q != IDLE;
  assign done = (state_q == FIN) & ~annul;
  assign quotient = quo_q;
  assign remainder = res_q;
  assign div_by_zero = dbz_q;
  // A zero divisor parks the raw dividend in dvd_q and pre-loads the terminal count,
  // so the next edge goes straight to FIN.
  always_comb begin
    state_d = state_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    res_d = res_q;
    cnt_d = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d = dz_q;
    dbz_d = dbz_q;
    if (annul) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        state_d = DIV;
        dz_d = opb_zero;
        dvd_d = (signed_op & opa[DATA_W-1] & ~opb_zero) ? -opa : opa;
        dvs_d = (signed_op & opb[DATA_W-1]) ? -opb : opb;
        rem_d = '0;
        cnt_d = opb_zero ? CW'(DATA_W) : '0;
        q_neg_d = signed_op & (opa[DATA_W-1] ^ opb[DATA_W-1]);
        r_neg_d = signed_op & opa[DATA_W-1];
      end
      DIV: if (cnt_q == CW'(DATA_W)) begin
        state_d = FIN;
        quo_d = dz_q ? '1 : q_neg_q ? -dvd_q : dvd_q;
        res_d = dz_q ? dvd_q : r_neg_q ? -rem_q : rem_q;
        dbz_d = dz_q;
      end else begin
        rem_d = ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
        dvd_d = {dvd_q[DATA_W-2:0], ge};
        cnt_d = cnt_q + CW'(1);
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q <= dz_d;
      dbz_q <= dbz_d;
    end
  end
endmodule
